frame_block_writer: RTL and testbench

- Ingress stage directly upstream of the blocked sram.
- Packs a byte-wide frame stream into BLOCK_BITS-wide blocks and takes one free block address per block from the free-block allocator.
- Writes each block into sram and chains the frame's blocks through a link-table write port.
- Emits one descriptor per frame (head address, byte length, block count) to the queueing logic.

---
 rtl/frame_block_writer.sv | 173 +++++++++++++++++
 tb/tb_frame_block_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_block_writer.sv
// frame_block_writer
//   Packs a byte-wide frame stream into BLOCK_BITS-wide blocks. Each block takes
//   one free address from the allocator, is written to the block sram, and is
//   chained to the previous block of the frame through the link table. One
//   descriptor (head, byte length, block count, truncated) is emitted per frame.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready/in_data/in_last  byte stream in
//   alloc_req/alloc_gnt/alloc_addr     free-block allocator (same-cycle grant)
//   we/w_addr/wdata                    sram write port
//   link_we/link_addr/link_next        link-table write port
//   desc_valid/desc_ready/desc_*       frame descriptor out

package mem_pkg;
  parameter int ADDR_W     = 4;
  parameter int BLOCK_BITS = 32;
endpackage

module frame_block_writer #(
  parameter  int ADDR_W          = mem_pkg::ADDR_W,
  parameter  int BLOCK_BITS      = mem_pkg::BLOCK_BITS,
  parameter  int MAX_FRAME_BYTES = 1522,
  localparam int BYTES           = BLOCK_BITS / 8,
  localparam int LEN_W           = $clog2(MAX_FRAME_BYTES + 1),
  localparam int NB_W            = $clog2((MAX_FRAME_BYTES + BYTES - 1) / BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  alloc_req,
  input  logic                  alloc_gnt,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic                  we,
  output logic [ADDR_W-1:0]     w_addr,
  output logic [BLOCK_BITS-1:0] wdata,
  output logic                  link_we,
  output logic [ADDR_W-1:0]     link_addr,
  output logic [ADDR_W-1:0]     link_next,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_W-1:0]     desc_head,
  output logic [LEN_W-1:0]      desc_len,
  output logic [NB_W-1:0]       desc_nblocks,
  output logic                  desc_trunc
);

  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {FILL, ALLOC, WRITE, DESC} state_t;

  state_t                r_state, w_next;
  logic                  r_live;    // keeps in_ready low while in reset
  logic [BLOCK_BITS-1:0] r_buf;
  logic [BIDX_W-1:0]     r_bidx;    // next byte slot in r_buf
  logic [LEN_W-1:0]      r_len;
  logic [NB_W-1:0]       r_nb;
  logic                  r_trunc;
  logic                  r_ended;   // in_last seen for the current frame
  logic [ADDR_W-1:0]     r_cur, r_prev, r_head;

  logic w_acc, w_full, w_blk_end, w_nonempty;

  assign w_acc      = in_valid & in_ready;
  assign w_full     = (r_len == LEN_W'(MAX_FRAME_BYTES));
  assign w_blk_end  = (r_bidx == BIDX_W'(BYTES - 1));
  assign w_nonempty = (r_bidx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    alloc_req  = 1'b0;
    we         = 1'b0;
    link_we    = 1'b0;
    desc_valid = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = r_live;
        if (w_acc) begin
          if (!w_full) begin
            if (w_blk_end || in_last) w_next = ALLOC;
          end else if (in_last) begin
            // dropped bytes only matter when they end the frame
            w_next = w_nonempty ? ALLOC : DESC;
          end
        end
      end
      ALLOC: begin
        alloc_req = 1'b1;
        if (alloc_gnt) w_next = WRITE;
      end
      WRITE: begin
        we      = 1'b1;
        link_we = (r_nb != '0);   // first block has no predecessor
        w_next  = r_ended ? DESC : FILL;
      end
      DESC: begin
        desc_valid = 1'b1;
        if (desc_ready) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_buf   <= '0;
      r_bidx  <= '0;
      r_len   <= '0;
      r_nb    <= '0;
      r_trunc <= 1'b0;
      r_ended <= 1'b0;
      r_cur   <= '0;
      r_prev  <= '0;
      r_head  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        FILL: begin
          if (w_acc) begin
            if (in_last) r_ended <= 1'b1;
            if (!w_full) begin
              for (int k = 0; k < BYTES; k++)
                if (r_bidx == BIDX_W'(k)) r_buf[8*k +: 8] <= in_data;
              r_bidx <= r_bidx + BIDX_W'(1);
              r_len  <= r_len + LEN_W'(1);
            end else begin
              r_trunc <= 1'b1;
            end
          end
        end
        ALLOC: begin
          if (alloc_gnt) r_cur <= alloc_addr;
        end
        WRITE: begin
          if (r_nb == '0) r_head <= r_cur;
          r_nb   <= r_nb + NB_W'(1);
          r_prev <= r_cur;
          r_buf  <= '0;
          r_bidx <= '0;
        end
        DESC: begin
          if (desc_ready) begin
            r_len   <= '0;
            r_nb    <= '0;
            r_trunc <= 1'b0;
            r_ended <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addr       = r_cur;
  assign wdata        = r_buf;
  assign link_addr    = r_prev;
  assign link_next    = r_cur;
  assign desc_head    = r_head;
  assign desc_len     = r_len;
  assign desc_nblocks = r_nb;
  assign desc_trunc   = r_trunc;

endmodule

// File: tb/tb_frame_block_writer.sv
// Bench for frame_block_writer with BLOCK_BITS=32, ADDR_W=4, MAX_FRAME_BYTES=16.
// Expected writes, links and descriptors are queued by each test and checked
// by a negedge monitor as the DUT produces them; a small allocator model
// serves grant addresses from a queue.

module tb_frame_block_writer;

  localparam int AW = 4, BB = 32, MAXB = 16, LW = 5, NW = 3;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_last;
  logic [7:0]    in_data;
  logic          alloc_req, alloc_gnt;
  logic [AW-1:0] alloc_addr;
  logic          we, link_we;
  logic [AW-1:0] w_addr, link_addr, link_next, desc_head;
  logic [BB-1:0] wdata;
  logic          desc_valid, desc_ready, desc_trunc;
  logic [LW-1:0] desc_len;
  logic [NW-1:0] desc_nblocks;

  frame_block_writer #(.ADDR_W(AW), .BLOCK_BITS(BB), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
    .we(we), .w_addr(w_addr), .wdata(wdata),
    .link_we(link_we), .link_addr(link_addr), .link_next(link_next),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_head(desc_head),
    .desc_len(desc_len), .desc_nblocks(desc_nblocks), .desc_trunc(desc_trunc)
  );

  typedef struct packed {logic [3:0] a; logic [31:0] d;} wr_t;
  typedef struct packed {logic [3:0] a; logic [3:0] n;} lk_t;
  typedef struct packed {logic [3:0] h; logic [4:0] len; logic [2:0] nb; logic tr;} ds_t;

  wr_t           wq[$];
  lk_t           lq[$];
  ds_t           dq[$];
  logic [AW-1:0] gq[$];
  bit            hold;
  int            checks = 0, failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // allocator model: grants the head of gq whenever requested and not held
  always @(negedge clk) begin
    if (alloc_gnt && gq.size() != 0) void'(gq.pop_front());
    alloc_gnt  = rst_n && alloc_req && !hold && (gq.size() != 0);
    alloc_addr = (gq.size() != 0) ? gq[0] : '0;
  end

  // scoreboard monitor
  bit  desc_seen = 0;
  wr_t ew;
  lk_t el;
  ds_t ed, gd;
  always @(negedge clk) begin
    if (rst_n) begin
      if (we === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected got addr=%0h data=%h", w_addr, wdata);
        end else begin
          ew = wq.pop_front();
          if (w_addr !== ew.a || wdata !== ew.d) begin
            failures++;
            $display("FAIL write got addr=%0h data=%h exp addr=%0h data=%h", w_addr, wdata, ew.a, ew.d);
          end
        end
      end
      if (link_we === 1'b1) begin
        checks++;
        if (lq.size() == 0) begin
          failures++;
          $display("FAIL link_unexpected got addr=%0h next=%0h", link_addr, link_next);
        end else begin
          el = lq.pop_front();
          if (link_addr !== el.a || link_next !== el.n) begin
            failures++;
            $display("FAIL link got %0h->%0h exp %0h->%0h", link_addr, link_next, el.a, el.n);
          end
        end
      end
      if (desc_valid === 1'b1 && !desc_seen) begin
        checks++;
        gd = {desc_head, desc_len, desc_nblocks, desc_trunc};
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL desc_unexpected got %h", gd);
        end else begin
          ed = dq.pop_front();
          if (gd !== ed) begin
            failures++;
            $display("FAIL desc got head=%0h len=%0d nb=%0d tr=%0b exp head=%0h len=%0d nb=%0d tr=%0b",
                     gd.h, gd.len, gd.nb, gd.tr, ed.h, ed.len, ed.nb, ed.tr);
          end
        end
      end
      desc_seen = (desc_valid === 1'b1);
    end else begin
      desc_seen = 0;
    end
  end

  // drive one byte; starts and ends on a negedge
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL send_timeout byte=%h in_ready=%b exp 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_seq(input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] b = first;
    for (int i = 0; i < n; i++) begin
      send_byte(b, i == n - 1);
      b = b + step;
    end
  endtask

  task automatic wait_desc();
    int n = 0;
    while (!(desc_valid === 1'b1 && desc_ready === 1'b1) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL desc_timeout desc_valid=%b exp 1", desc_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    desc_ready = 1'b1; hold = 1'b0; alloc_gnt = 1'b0; alloc_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, alloc_req, we, link_we, desc_valid, desc_trunc} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b exp 000000", {in_ready, alloc_req, we, link_we, desc_valid, desc_trunc});
    end
    checks++;
    if ({w_addr, wdata, link_addr, link_next, desc_head, desc_len, desc_nblocks} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%0h wdata=%h head=%0h len=%0d nb=%0d exp all 0",
               w_addr, wdata, desc_head, desc_len, desc_nblocks);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b exp 1", in_ready);
    end
  endtask

  task automatic test_single();
    gq.push_back(4'd5);
    wq.push_back({4'd5, 32'h44332211});
    dq.push_back({4'd5, 5'd4, 3'd1, 1'b0});
    send_seq(4, 8'h11, 8'h11);
    wait_desc();
  endtask

  task automatic test_two_blocks();
    gq.push_back(4'd3); gq.push_back(4'd9);
    wq.push_back({4'd3, 32'h04030201});
    wq.push_back({4'd9, 32'h00000605});
    lq.push_back({4'd3, 4'd9});
    dq.push_back({4'd3, 5'd6, 3'd2, 1'b0});
    send_seq(6, 8'h01, 8'h01);
    wait_desc();
  endtask

  task automatic test_alloc_stall();
    hold = 1'b1;
    gq.push_back(4'd7);
    wq.push_back({4'd7, 32'h24232221});
    dq.push_back({4'd7, 5'd4, 3'd1, 1'b0});
    send_seq(4, 8'h21, 8'h01);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({alloc_req, in_ready, we} !== 3'b100) begin
        failures++;
        $display("FAIL alloc_stall cyc=%0d req/rdy/we=%b exp 100", i, {alloc_req, in_ready, we});
      end
      @(negedge clk);
    end
    #1 hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || w_addr !== 4'd7) begin
      failures++;
      $display("FAIL alloc_release we=%b addr=%0h exp we=1 addr=7", we, w_addr);
    end
    wait_desc();
  endtask

  task automatic test_trunc();
    for (int i = 1; i <= 4; i++) gq.push_back(AW'(i));
    wq.push_back({4'd1, 32'h04030201});
    wq.push_back({4'd2, 32'h08070605});
    wq.push_back({4'd3, 32'h0C0B0A09});
    wq.push_back({4'd4, 32'h100F0E0D});
    lq.push_back({4'd1, 4'd2}); lq.push_back({4'd2, 4'd3}); lq.push_back({4'd3, 4'd4});
    dq.push_back({4'd1, 5'd16, 3'd4, 1'b1});
    send_seq(20, 8'h01, 8'h01);
    wait_desc();
  endtask

  task automatic test_desc_stall();
    int n = 0;
    desc_ready = 1'b0;
    gq.push_back(4'd6);
    wq.push_back({4'd6, 32'h0000BBAA});
    dq.push_back({4'd6, 5'd2, 3'd1, 1'b0});
    send_seq(2, 8'hAA, 8'h11);
    while (desc_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({desc_valid, in_ready, desc_head, desc_len, desc_nblocks, desc_trunc} !==
          {1'b1, 1'b0, 4'd6, 5'd2, 3'd1, 1'b0}) begin
        failures++;
        $display("FAIL desc_hold cyc=%0d valid=%b rdy=%b head=%0h len=%0d nb=%0d exp 1 0 6 2 1",
                 i, desc_valid, in_ready, desc_head, desc_len, desc_nblocks);
      end
      @(negedge clk);
    end
    desc_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, desc_valid, desc_len, desc_nblocks, desc_trunc} !== {1'b1, 1'b0, 5'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL desc_after rdy=%b valid=%b len=%0d nb=%0d exp rdy=1 valid=0 len=0 nb=0",
               in_ready, desc_valid, desc_len, desc_nblocks);
    end
  endtask

  task automatic test_reset_mid();
    gq.push_back(4'd10);
    wq.push_back({4'd10, 32'h04030201});
    send_seq(6, 8'h01, 8'h01);
    repeat (2) @(negedge clk);
    checks++;
    if (alloc_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_alloc alloc_req=%b exp 1", alloc_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, alloc_req, we, link_we, desc_valid, desc_trunc} !== 6'b0 ||
        {w_addr, wdata, link_addr, link_next, desc_head, desc_len, desc_nblocks} !== '0) begin
      failures++;
      $display("FAIL mid_reset ctrl=%b addr=%0h head=%0h len=%0d nb=%0d exp all 0",
               {in_ready, alloc_req, we, link_we, desc_valid, desc_trunc}, w_addr, desc_head, desc_len, desc_nblocks);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gq.push_back(4'd12);
    wq.push_back({4'd12, 32'h00006B5A});
    dq.push_back({4'd12, 5'd2, 3'd1, 1'b0});
    send_seq(2, 8'h5A, 8'h11);
    wait_desc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_blocks();
    test_alloc_stall();
    test_trunc();
    test_desc_stall();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() != 0 || lq.size() != 0 || dq.size() != 0 || gq.size() != 0) begin
      failures++;
      $display("FAIL drained writes=%0d links=%0d descs=%0d grants=%0d exp 0 0 0 0",
               wq.size(), lq.size(), dq.size(), gq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
